// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_DISP = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way round-robin selector: eligible valids, preferred port
// and an ownership mask in, one-hot grant out.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] elig_s;

  // Contention is settled by the pointer; a lone eligible port always wins.
  always_comb begin
    elig_s = valid & mask;
    if (elig_s == 2'b11) begin
      grant = (ptr == PORT_DISP) ? 2'b10 : 2'b01;
    end else begin
      grant = elig_s;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with lock ownership sharing the data memory between
// the CPU load/store path (port 0) and the display reader (port 1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int Width     = 32,
  parameter int AddrWidth = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic                 req0_lock,
  input  logic [AddrWidth-1:0] req0_addr,
  input  logic [Width-1:0]     req0_wdata,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic                 req1_lock,
  input  logic [AddrWidth-1:0] req1_addr,
  input  logic [Width-1:0]     req1_wdata,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic [Width-1:0]     rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [Width-1:0]     rsp1_rdata,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic [Width-1:0]     ALUResult,
  output logic [Width-1:0]     WriteData,
  input  logic [Width-1:0]     ReadData
);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [Width-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [Width-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic [1:0] mask_s;
  logic [1:0] pick_s;
  logic [1:0] grant_s;
  logic       acc_s;
  logic       acc_port_s;
  logic       acc_lock_s;

  // Ownership restricts which ports the selector may consider.
  always_comb begin
    case (state_q)
      IDLE:    mask_s = 2'b11;
      OWN0:    mask_s = 2'b01;
      OWN1:    mask_s = 2'b10;
      default: mask_s = 2'b11;
    endcase
  end

  dmem_rr_pick u_pick (
    .valid (pick_valid_s()),
    .ptr   (ptr_q),
    .mask  (mask_s),
    .grant (pick_s)
  );

  function automatic logic [1:0] pick_valid_s();
    return {req1_valid, req0_valid};
  endfunction

  // Holding reset masks the grant so no memory strobe can leak out.
  assign grant_s    = pick_s & {2{rst_n}};
  assign acc_s      = |grant_s;
  assign acc_port_s = grant_s[1];
  assign acc_lock_s = acc_port_s ? req1_lock : req0_lock;
  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];

  // Memory interface follows the granted request, all zero when idle.
  always_comb begin
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    if (grant_s[0]) begin
      MemWrite  = req0_write;
      MemRead   = ~req0_write;
      ALUResult = {{(Width-AddrWidth){1'b0}}, req0_addr};
      WriteData = req0_wdata;
    end else if (grant_s[1]) begin
      MemWrite  = req1_write;
      MemRead   = ~req1_write;
      ALUResult = {{(Width-AddrWidth){1'b0}}, req1_addr};
      WriteData = req1_wdata;
    end else begin
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
    end
  end

  // Ownership FSM and pointer; the pointer is frozen while a lock is held.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (acc_s) begin
          ptr_d   = ~acc_port_s;
          state_d = acc_lock_s ? (acc_port_s ? OWN1 : OWN0) : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (acc_s && !acc_lock_s) begin
          state_d = IDLE;
          ptr_d   = ~acc_port_s;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = PORT_CPU;
      end
    endcase
  end

  // Response capture: loads return memory data, stores return zero.
  always_comb begin
    rsp0_valid_d = grant_s[0];
    rsp1_valid_d = grant_s[1];
    if (grant_s[0]) begin
      rsp0_rdata_d = req0_write ? '0 : ReadData;
    end else begin
      rsp0_rdata_d = rsp0_rdata_q;
    end
    if (grant_s[1]) begin
      rsp1_rdata_d = req1_write ? '0 : ReadData;
    end else begin
      rsp1_rdata_d = rsp1_rdata_q;
    end
  end

  // State, pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= PORT_CPU;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-ported data memory between the CPU load/store path (port 0) and the display/debug reader that scans results for the 7-segment output (port 1). It drives the memory's combinational-read, clocked-write interface directly and returns one registered response per accepted request. Arbitration is round-robin, with an optional lock that gives one port exclusive ownership for read-modify-write sequences.

## Interface
- Width, 32, data and memory-address bus width
- AddrWidth, 9, significant word-address bits (512-word memory)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_write / req1_write  in  1  1 = store, 0 = load
- req0_lock / req1_lock  in  1  hold ownership after this request is accepted
- req0_addr / req1_addr  in  AddrWidth  word address
- req0_wdata / req1_wdata  in  Width  store data
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  Width  load data; 0 for stores
- MemWrite  out  1  memory write enable
- MemRead  out  1  memory read enable
- ALUResult  out  Width  memory address, {zeros, granted addr}
- WriteData  out  Width  memory write data
- ReadData  in  Width  combinational memory read data

## Operation
- Grant: at most one port per cycle. readyX = grant to X and reqX_valid. A grant happens only when the granted port is valid.
- Memory outputs follow the granted request combinationally: MemWrite = granted & write, MemRead = granted & ~write. When idle, the outputs are MemWrite=0, MemRead=0, ALUResult=0, WriteData=0.
- While rst_n=0, MemWrite and MemRead are forced to 0.
- Round-robin: the 1-bit priority pointer names the preferred port and resets to 0. After any accepted request from port X, the pointer becomes ~X. If only one port is valid, that port wins regardless of the pointer.
- FSM states:
  - IDLE: normal round-robin.
  - OWN0: only port 0 can be granted; req1_ready=0.
  - OWN1: only port 1 can be granted; req0_ready=0.
- FSM transitions:
  - IDLE to OWNX: on an accepted port-X request with lock=1.
  - OWNX to IDLE: on an accepted port-X request with lock=0.
  - In OWNX, idle cycles (port X not valid) retain ownership.
  - The pointer is not updated while in OWNX. On return to IDLE, the pointer is set to ~X.
- Response: on the accept edge, rspX_valid is set for exactly one cycle. rspX_rdata captures ReadData for a load, or 0 for a store. A non-accepted port keeps rsp_valid=0 and holds its previous rdata.
- Address width: ALUResult[Width-1:AddrWidth] is always 0.

## Timing
- Reset values:
  - state IDLE, pointer 0
  - rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0
  - combinational outputs as in the idle case above
- Latency: request accepted at edge N gives its response valid in cycle N+1. A store is committed to memory at edge N.
- Throughput: one access per cycle. Back-to-back accepts on the same port give back-to-back response pulses.
- A load immediately after a store to the same address (next cycle) returns the new data.
- Simultaneous valid in IDLE: the pointer port wins. The loser sees ready=0 and must hold its request stable until accepted.
- Reset asserted mid-lock: return to IDLE and pointer 0 immediately. Any in-flight response is dropped.

## Structure
- Package dmem_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1}
  - port index constants PORT_CPU=0, PORT_DISP=1
- One sub-module: dmem_rr_pick, a pure combinational 2-way round-robin selector (valids, pointer, ownership mask → grant one-hot).
- The FSM, pointer and response registers live in dmem_arbiter.

## Test plan
- Single load: memory[5]=0x1234; port0 loads addr 5 → ready0=1 the same cycle; rsp0_valid=1 next cycle with rdata=0x1234; rsp1_valid stays 0.
- Contention: both ports load every cycle from reset → grants alternate 0,1,0,1; each port gets a response every other cycle; MemWrite stays 0.
- Store-then-load: port0 stores 0xDEADBEEF to addr 3, then port1 loads addr 3 → rsp1_rdata=0xDEADBEEF; the store's rsp0_rdata=0.
- Lock: port1 issues a lock load of addr 7, then holds valid low for 2 cycles while port0 is valid → req0_ready=0 throughout; port1's unlocked store then releases ownership, and port0 is granted the next cycle.
- Address width: port0 address 0x1FF → ALUResult=0x000001FF, upper bits 0.
- Reset mid-lock: assert rst_n=0 in OWN0 → MemRead=MemWrite=0 and rsp valids=0 asynchronously; after release both ports are valid and port0 wins first.
